// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory_access load/store stage.
package memory_access_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Access size codes carried in funct3[1:0]
    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    // funct3 bit selecting zero-extension on loads
    localparam int unsigned F3_UNSIGNED = 2;

    // True when the access size cannot be performed at the given byte offset
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Request/acknowledge bus between the load/store stage and data memory.
interface memory_access_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/memory_access_load_align_extend.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module load_align_extend
    import memory_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;
    logic            zext;

    // Shift the addressed byte lane down to bit 0, then extend per size
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        zext    = funct3[F3_UNSIGNED];
        case (funct3[1:0])
            SZ_BYTE: result = {{(XLEN-8){~zext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: result = {{(XLEN-16){~zext & shifted[15]}}, shifted[15:0]};
            SZ_WORD: result = shifted;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Load/store stage: drives the data-memory handshake, aligns load data,
// flags misaligned and timed-out accesses, and forwards the branch decision.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_load,
    input  logic             is_store,
    input  logic [XLEN-1:0]  alu_res,
    input  logic [XLEN-1:0]  store_data,
    input  logic [2:0]       funct3,
    input  logic             branch_taken_in,
    input  logic [XLEN-1:0]  branch_target_in,
    memory_access_if.master  mem,
    output logic [XLEN-1:0]  wb_data,
    output logic             branch_taken_out,
    output logic [XLEN-1:0]  branch_target_out,
    output logic             done,
    output logic             busy,
    output logic             fault_misaligned,
    output logic             fault_bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [XLEN-1:0]   cap_addr;
    logic [XLEN-1:0]   cap_data;
    logic [2:0]        cap_funct3;
    logic              cap_load;
    logic              cap_store;

    logic              is_mem;
    logic              start_misaligned;
    logic              cap_write;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   wdata_enc;
    logic [3:0]        wstrb_enc;

    // Load and store both high is treated as a load
    assign is_mem           = is_load | is_store;
    assign start_misaligned = is_mem & is_misaligned(funct3[1:0], alu_res[1:0]);
    assign cap_write        = cap_store & ~cap_load;

    load_align_extend #(
        .XLEN (XLEN)
    ) u_align (
        .rdata  (mem.mem_rdata),
        .offset (cap_addr[1:0]),
        .funct3 (cap_funct3),
        .result (load_data)
    );

    // Store lane replication and byte strobes from the captured request
    always_comb begin
        wdata_enc = '0;
        wstrb_enc = '0;
        case (cap_funct3[1:0])
            SZ_BYTE: begin
                wdata_enc = {4{cap_data[7:0]}};
                wstrb_enc = 4'b0001 << cap_addr[1:0];
            end
            SZ_HALF: begin
                wdata_enc = {2{cap_data[15:0]}};
                wstrb_enc = 4'b0011 << cap_addr[1:0];
            end
            SZ_WORD: begin
                wdata_enc = cap_data;
                wstrb_enc = 4'b1111;
            end
            default: begin
                wdata_enc = '0;
                wstrb_enc = '0;
            end
        endcase
    end

    // Bus outputs decoded from state and the captured request fields
    assign mem.mem_req   = (state == ST_REQ);
    assign mem.mem_we    = (state == ST_REQ) & cap_write;
    assign mem.mem_addr  = {cap_addr[XLEN-1:2], 2'b00};
    assign mem.mem_wdata = wdata_enc;
    assign mem.mem_wstrb = ((state == ST_REQ) && cap_write) ? wstrb_enc : 4'b0000;
    assign busy          = (state != ST_IDLE);

    // Transaction FSM with registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            tmo_cnt           <= '0;
            cap_addr          <= '0;
            cap_data          <= '0;
            cap_funct3        <= '0;
            cap_load          <= 1'b0;
            cap_store         <= 1'b0;
            wb_data           <= '0;
            branch_taken_out  <= 1'b0;
            branch_target_out <= '0;
            done              <= 1'b0;
            fault_misaligned  <= 1'b0;
            fault_bus         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cap_addr          <= alu_res;
                        cap_data          <= store_data;
                        cap_funct3        <= funct3;
                        cap_load          <= is_load;
                        cap_store         <= is_store;
                        branch_taken_out  <= branch_taken_in;
                        branch_target_out <= branch_target_in;
                        fault_misaligned  <= 1'b0;
                        fault_bus         <= 1'b0;
                        tmo_cnt           <= '0;
                        if (!is_mem) begin
                            wb_data <= alu_res;
                            state   <= ST_DONE;
                        end else if (start_misaligned) begin
                            wb_data          <= '0;
                            fault_misaligned <= 1'b1;
                            state            <= ST_DONE;
                        end else begin
                            wb_data <= '0;
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over an expiring timeout
                    if (mem.mem_ack) begin
                        wb_data <= cap_write ? '0 : load_data;
                        state   <= ST_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        wb_data   <= '0;
                        fault_bus <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Load/store stage directly downstream of the execute stage in the non-pipelined core.
- Consumes the ALU result as the effective address, the propagated second register as store data, and the propagated funct3.
- Runs a request/acknowledge transaction with data memory, aligns and extends load data, and flags misaligned or timed-out accesses.
- Passes the branch decision and branch target through to writeback/PC-update, together with a one-cycle done pulse.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TIMEOUT, 16, maximum number of REQ cycles without mem_ack before a bus error is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  EX outputs valid; sampled only in IDLE
- is_load  in  1  operation is a load
- is_store  in  1  operation is a store; is_load and is_store both high is treated as a load
- alu_res  in  XLEN  EX result; used as the address for load/store, passed through otherwise
- store_data  in  XLEN  rs2 value from EX
- funct3  in  3  access size/sign: [1:0] 0=byte, 1=half, 2=word, 3=illegal; [2]=1 unsigned load
- branch_taken_in  in  1  EX branch decision
- branch_target_in  in  XLEN  EX branch target
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  XLEN  word-aligned address, {alu_res[XLEN-1:2],2'b00}
- mem_wdata  out  XLEN  lane-replicated store data
- mem_wstrb  out  4  byte write strobes; 0 on loads
- mem_ack  in  1  memory completion
- mem_rdata  in  XLEN  read word, valid when mem_ack=1
- wb_data  out  XLEN  load result or passed-through alu_res
- branch_taken_out  out  1  registered copy of branch_taken_in
- branch_target_out  out  XLEN  registered copy of branch_target_in
- done  out  1  one-cycle completion pulse
- busy  out  1  high whenever state != IDLE
- fault_misaligned  out  1  misaligned or illegal-size access
- fault_bus  out  1  timeout reached without mem_ack

Behaviour:
- The clock input is clk; the reset input is rst; there is one clock.
- Reset is synchronous and active-high: state goes to IDLE.
- Every registered output resets to 0: wb_data, branch_*_out, done, both faults, the timeout counter and the captured request fields.
- mem_req, mem_we, mem_wstrb and busy are decoded from the state register, so they are 0 in the cycle after the reset edge.
- A reset during REQ abandons the transaction; a late mem_ack is then ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE, start=1:
  - Register alu_res, store_data, funct3, is_load/is_store and the branch inputs.
  - Clear both faults.
  - No memory op: next state DONE, wb_data=alu_res. Total latency is 2 cycles from start to done.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0, or size code 3): next state DONE, fault_misaligned=1, wb_data=0, no mem_req issued.
  - Otherwise: next state REQ, timeout counter cleared.
- IDLE, start=0: stay in IDLE; mem_ack is ignored.
- REQ:
  - mem_req=1 with mem_addr, mem_we, mem_wdata and mem_wstrb held stable until the ack or timeout cycle.
  - mem_ack=1 (including on the first REQ cycle): next state DONE.
  - Load data is extracted at lane alu_res[1:0] and then sign- or zero-extended per funct3[2].
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT-1 with no ack, the next state is DONE with fault_bus=1 and wb_data=0.
  - mem_ack and the timeout in the same cycle: the ack wins.
- Store encoding:
  - byte: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0]
  - half: wdata={2{d[15:0]}}, wstrb=4'b0011<<addr[1:0]
  - word: wdata=d, wstrb=4'b1111
  - Stores write wb_data=0.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored while busy.
- wb_data, branch_*_out and the faults hold their values until the next accepted start.

Decomposition:
- Shared package holds:
  - the state encoding;
  - size codes SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - the unsigned-bit index 2.
- One natural combinational sub-module, load_align_extend: inputs rdata, byte offset and funct3; output is the extended XLEN result.
- Store replication and strobe generation stay inline.

Test Plan:
- Non-memory op: start with alu_res=0x0000_1234, is_load=0, is_store=0, branch_taken_in=1, branch_target_in=0x80 -> done two cycles later, wb_data=0x1234, branch_taken_out=1, branch_target_out=0x80, mem_req never asserted.
- Signed byte load: addr=0x103, funct3=0, mem_rdata=0x80FF_0000 with ack after 3 cycles -> mem_addr=0x100, mem_req held 3 cycles, wb_data=0xFFFF_FF80. The same case with funct3=4 gives 0x0000_0080.
- Half store: addr=0x206, funct3=1, store_data=0xDEAD_BEEF, ack on the first REQ cycle -> mem_we=1, mem_wstrb=4'b1100, mem_wdata=0xBEEF_BEEF, done one cycle later.
- Misaligned word load: addr=0x302, funct3=2 -> fault_misaligned=1 on done, wb_data=0, zero mem_req cycles.
- Timeout: load from 0x400, mem_ack held 0 -> mem_req high for exactly TIMEOUT (16) cycles, then done with fault_bus=1. An ack arriving afterwards is ignored.
- Reset mid-REQ: rst asserted on the 2nd REQ cycle -> mem_req=0, busy=0, all outputs 0 on the following cycle. A new start then completes normally.
